// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Program-counter owner and instruction-fetch sequencer for the RV32I core.
//   Each instruction runs FETCH (request held until imem_ready) and then EXEC
//   (held while stall is high). At commit the next PC is picked from halt,
//   JALR, JAL/taken branch or sequential. A target with bit 1 set is
//   redirected to TRAP_PC with a one-cycle trap pulse.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         fetch request and address (address = pc)
//   imem_ready/imem_rdata      fetch completion and fetched word
//   instr/instr_valid          registered instruction and EXEC indicator
//   pc/pc_plus4                current instruction address and link value
//   base_sel                   jump-base mux select (1 = rs1, JALR in EXEC)
//   is_branch, branch_taken,
//   is_jal, is_jalr, imm, rs1  decoded control and operands for instr
//   stall                      holds commit while execute is busy
//   halt                       ecall/ebreak: stop after commit
//   trap                       pulse after a misaligned-target redirect
//   halted                     sequencer stopped until reset
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        base_sel,
   input  logic        is_branch,
   input  logic        branch_taken,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        stall,
   input  logic        halt,
   output logic        trap,
   output logic        halted
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        trap_q, trap_d;
   logic [31:0] target;

   // Jump/branch target selection. JALR wins over JAL; branch_taken only
   // matters for branches. Additions wrap modulo 2^32.
   function automatic logic [31:0] next_target(
      input logic [31:0]        cur_pc,
      input logic [31:0]        base_rs1,
      input logic signed [31:0] offset,
      input logic               f_jalr,
      input logic               f_jal,
      input logic               f_branch,
      input logic               f_taken
   );
      logic [31:0] t;
      if (f_jalr)
         t = (base_rs1 + $unsigned(offset)) & 32'hFFFF_FFFE;
      else if (f_jal || (f_branch && f_taken))
         t = cur_pc + $unsigned(offset);
      else
         t = cur_pc + 32'd4;
      return t;
   endfunction

   assign target = next_target(pc_q, rs1, $signed(imm), is_jalr, is_jal,
                               is_branch, branch_taken);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RESET;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         trap_q  <= trap_d;
      end
   end

   // Next-state and next-PC logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      trap_d  = 1'b0;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               if (halt) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_HALT;
               end else begin
                  // Only bit 1 is checked: bit 0 of JALR targets is already
                  // cleared, and branch/JAL offsets are even by encoding.
                  if (target[1]) begin
                     pc_d   = TRAP_PC;
                     trap_d = 1'b1;
                  end else begin
                     pc_d = target;
                  end
                  state_d = S_FETCH;
               end
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   // Outputs are decoded from registered state, so they return to reset
   // values as soon as rst_n falls.
   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state_q == S_EXEC);
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign base_sel    = (state_q == S_EXEC) && is_jalr;
   assign trap        = trap_q;
   assign halted      = (state_q == S_HALT);

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Multi-cycle program-counter and fetch sequencer for the RV32I core. It owns the PC register and runs the instruction-memory fetch handshake. It computes the next PC, selecting sequential, branch/JAL (PC-relative) or JALR (rs1-relative) targets, and drives the select line of the PC/rs1 jump-base mux. It sits between instruction memory and the decode/execute datapath, and replaces the free-running PC update with a handshake-aware, stallable sequence.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_PC, 32'h0000_0100, PC loaded on misaligned jump/branch target
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until imem_ready
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  imem_rdata valid this cycle; completes fetch
- imem_rdata  in  32  fetched instruction word
- instr  out  32  registered instruction presented to decode
- instr_valid  out  1  instr is in execute; commits on instr_valid & !stall
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4, for JAL/JALR link value
- base_sel  out  1  jump-base mux select: 0 = pc, 1 = rs1
- is_branch, branch_taken, is_jal, is_jalr  in  1 each  decoded control for instr
- imm  in  32  sign-extended immediate
- rs1  in  32  rs1 register value
- stall  in  1  execute not finished (e.g. data memory busy); holds commit
- halt  in  1  ecall/ebreak decoded; stop after commit
- trap  out  1  one-cycle pulse: misaligned target redirected to TRAP_PC
- halted  out  1  sequencer stopped

## Operation
- States: RESET, FETCH, EXEC, HALT.
- RESET: entered asynchronously while rst_n = 0. On the first clk edge with rst_n = 1, go to FETCH.
- FETCH: imem_req = 1, imem_addr = pc. On imem_ready, latch instr <= imem_rdata and go to EXEC. Otherwise stay in FETCH with the request held and the address stable.
- EXEC: instr_valid = 1, imem_req = 0. base_sel = is_jalr (combinational). base_sel = 0 in all other states.
- Commit occurs in EXEC when stall = 0. While stall = 1, stay in EXEC and hold pc and instr.
- Next-PC priority at commit:
  - halt: pc <= pc_plus4, go to HALT.
  - is_jalr: target = (rs1 + imm) & ~32'h1.
  - is_jal, or is_branch & branch_taken: target = pc + imm.
  - otherwise: pc_plus4.
- All address arithmetic is modulo 2^32. Wrap-around is silent: pc 32'hFFFF_FFFC + 4 = 0.
- Misaligned target: bit 1 of the chosen target is set. Then pc <= TRAP_PC, trap = 1 for the one cycle after commit, and the state goes to FETCH.
- branch_taken is ignored when is_branch = 0.
- Simultaneous is_jal and is_jalr: jalr wins.
- After any non-halt commit, go to FETCH.
- HALT: halted = 1, imem_req = 0, instr_valid = 0. Only reset leaves HALT.
- Reset mid-fetch or mid-stall abandons the transaction. A late imem_ready is ignored until FETCH is re-entered.

## Timing
- Reset values: state RESET, pc = RESET_PC, instr = 32'h0000_0013 (NOP), imem_req = 0, instr_valid = 0, trap = 0, halted = 0. pc_plus4 = RESET_PC + 4 at all times (combinational).
- Minimum 2 cycles per instruction: FETCH with ready in the same cycle, then EXEC. Each FETCH wait cycle and each stall cycle adds 1.
- pc, instr, trap and halted are registered and update on the clk edge ending the commit or fetch cycle.
- imem_addr changes only on entry to FETCH.
- imem_req deasserts in the cycle after imem_ready is sampled.

## Test plan
- Reset/boot: hold rst_n = 0 for 3 cycles, then release with imem_ready = 1. Required: imem_addr = 0 on the cycle after release, instr_valid on the next cycle, pc sequence 0, 4, 8 with 2 cycles per instruction.
- Fetch wait plus stall: imem_ready low for 3 cycles, then stall high for 2 cycles in EXEC. Required: imem_req and addr held 3 cycles, instr_valid high 3 cycles, pc unchanged until stall drops.
- JALR: pc = 0x40, rs1 = 0x1001, imm = 4, is_jalr = 1. Required: base_sel = 1 in EXEC, next pc = 0x1004 (bit 0 cleared), pc_plus4 = 0x44.
- Branch/JAL: pc = 0x100, imm = -8. Required: taken branch gives 0xF8; is_branch with branch_taken = 0 gives 0x104; JAL gives 0xF8.
- Misaligned target and wrap: JAL with pc = 0x10, imm = 6. Required: trap pulses 1 cycle, pc = 0x100. Separately, sequential pc 0xFFFF_FFFC gives next pc 0x0.
- Halt and async reset: halt at pc = 0x20. Required: halted = 1, pc = 0x24, no further imem_req. Then pulse rst_n low mid-cycle: all outputs return to reset values immediately, without a clock edge.
